// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared state encoding, frame bit indices and edge helpers
//               for the UART receiver control path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Receiver control states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_t;

  // Bit indices reported by the edge/bit counter
  localparam logic [3:0] START_IDX      = 4'd0;
  localparam logic [3:0] LAST_DATA_IDX  = 4'd8;
  localparam logic [3:0] PAR_IDX        = 4'd9;
  localparam logic [3:0] STOP_IDX_NOPAR = 4'd9;
  localparam logic [3:0] STOP_IDX_PAR   = 4'd10;

  // Oversampling ratio held until the first frame configures the receiver
  localparam logic [5:0] RESET_PRESCALE = 6'd8;

  // Oversample index where the majority sampler result is settled
  function automatic logic [5:0] chk_edge(input logic [5:0] prescale);
    return (prescale >> 1) + 6'd2;
  endfunction

  // Last oversample index of a bit period
  function automatic logic [5:0] end_edge(input logic [5:0] prescale);
    return prescale - 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : Moore control FSM of the UART receiver. Sequences start,
//               data, optional parity and stop bits using the external
//               edge/bit counter, issues one-cycle sampling/check strobes
//               and reports frame status in a single DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic [3:0] bit_cnt,
  input  logic [4:0] edge_cnt,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       enable,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       par_err_o,
  output logic       stp_err_o
);

  rx_state_t  r_state;
  rx_state_t  w_next;

  logic [5:0] r_prescale;
  logic       r_par_en;
  logic       r_par_flag;
  logic       r_stp_flag;

  logic [5:0] w_chk_edge;
  logic [5:0] w_end_edge;
  logic       w_at_chk;
  logic       w_at_end;
  logic [3:0] w_stop_idx;

  // Edge decodes use the frame configuration latched while idle, so a
  // mid-frame change of Prescale or PAR_EN cannot shift the bit timing.
  assign w_chk_edge = chk_edge(r_prescale);
  assign w_end_edge = end_edge(r_prescale);
  assign w_at_chk   = ({1'b0, edge_cnt} == w_chk_edge);
  assign w_at_end   = ({1'b0, edge_cnt} == w_end_edge);
  assign w_stop_idx = r_par_en ? STOP_IDX_PAR : STOP_IDX_NOPAR;

  // State register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture frame configuration every idle cycle; frozen for the frame
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_prescale <= RESET_PRESCALE;
      r_par_en   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_prescale <= Prescale;
      r_par_en   <= PAR_EN;
    end
  end

  // Sticky parity/stop error flags, reported and cleared in DONE
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else if (r_state == DONE) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else begin
      if (par_chk_en && par_err) begin
        r_par_flag <= 1'b1;
      end
      if (stp_chk_en && stp_err) begin
        r_stp_flag <= 1'b1;
      end
    end
  end

  // Next-state and Moore output decode (state plus counter position)
  always_comb begin
    w_next      = r_state;
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    par_err_o   = 1'b0;
    stp_err_o   = 1'b0;

    case (r_state)
      IDLE: begin
        if (!RX_IN) begin
          w_next = START;
        end
      end

      START: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = w_at_chk;
        // A start bit that does not survive to mid-bit is line noise
        if (w_at_chk && strt_glitch) begin
          w_next = IDLE;
        end else if ((bit_cnt == START_IDX) && w_at_end) begin
          w_next = DATA;
        end
      end

      DATA: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = w_at_chk;
        if ((bit_cnt == LAST_DATA_IDX) && w_at_end) begin
          w_next = r_par_en ? PARITY : STOP;
        end
      end

      PARITY: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = w_at_chk && (bit_cnt == PAR_IDX);
        if (w_at_end) begin
          w_next = STOP;
        end
      end

      STOP: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = w_at_chk && (bit_cnt == w_stop_idx);
        if (w_at_end) begin
          w_next = DONE;
        end
      end

      DONE: begin
        data_valid = ~(r_par_flag | r_stp_flag);
        par_err_o  = r_par_flag;
        stp_err_o  = r_stp_flag;
        // A low line here is the next start bit; skip the idle cycle
        w_next     = RX_IN ? IDLE : START;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Directed bench for uart_rx_fsm with a behavioural edge/bit
//               counter and a frame-status scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [3:0] bit_cnt;
  logic [4:0] edge_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       enable;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       par_err_o;
  logic       stp_err_o;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .bit_cnt     (bit_cnt),
    .edge_cnt    (edge_cnt),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .enable      (enable),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .par_err_o   (par_err_o),
    .stp_err_o   (stp_err_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic dv;
    logic pe;
    logic se;
  } status_t;

  status_t    exp_q[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  // Stimulus state applied once per cycle
  bit         en_prev      = 1'b0;
  int         cur_p        = 8;
  bit         cur_pe       = 1'b0;
  bit         rx_level     = 1'b1;
  logic [5:0] prescale_drv = 6'd8;
  bit         paren_drv    = 1'b0;
  bit         inj_g        = 1'b0;
  bit         inj_p        = 1'b0;
  bit         inj_s        = 1'b0;

  // Edge/bit counter model
  int         m_edge = 0;
  int         m_bit  = 0;

  // Per-frame observations
  int         n_en, n_deser, n_strt, n_par, n_stp, n_bad, n_pulse, pulse_cyc;

  function automatic logic [8:0] outs();
    return {enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
            stp_chk_en, data_valid, par_err_o, stp_err_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_en = 0; n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0;
    n_bad = 0; n_pulse = 0; pulse_cyc = -1;
  endtask

  // One clock: advance the counter model, drive inputs, then observe
  task automatic cycle();
    status_t e;
    int      chkp;
    @(posedge CLK);
    #1;
    if (en_prev) begin
      if (m_edge == cur_p - 1) begin
        m_edge = 0;
        m_bit++;
      end else begin
        m_edge++;
      end
    end else begin
      m_edge = 0;
      m_bit  = 0;
    end
    chkp        = cur_p / 2 + 2;
    edge_cnt    = 5'(m_edge);
    bit_cnt     = 4'(m_bit);
    strt_glitch = inj_g && (m_edge == chkp);
    par_err     = inj_p && (m_edge == chkp);
    stp_err     = inj_s && (m_edge == chkp);
    RX_IN       = rx_level;
    Prescale    = prescale_drv;
    PAR_EN      = paren_drv;
    @(negedge CLK);
    en_prev = enable;
    if (enable) n_en++;
    if (dat_samp_en !== enable) n_bad++;
    if (deser_en) begin
      n_deser++;
      if (m_edge != chkp || m_bit < 1 || m_bit > 8) n_bad++;
    end
    if (strt_chk_en) begin
      n_strt++;
      if (m_edge != chkp || m_bit != 0) n_bad++;
    end
    if (par_chk_en) begin
      n_par++;
      if (m_edge != chkp || m_bit != 9) n_bad++;
    end
    if (stp_chk_en) begin
      n_stp++;
      if (m_edge != chkp || m_bit != 9 + int'(cur_pe)) n_bad++;
    end
    if (data_valid || par_err_o || stp_err_o) begin
      n_pulse++;
      pulse_cyc = cyc;
      chk("sb_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_valid", data_valid, e.dv);
        chk("par_err_o", par_err_o, e.pe);
        chk("stp_err_o", stp_err_o, e.se);
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    rx_level = 1'b1;
    repeat (n) cycle();
  endtask

  // One frame: start bit, 8 data bits LSB first, optional parity, stop
  task automatic run_frame(input int p, input bit pe, input logic [7:0] data,
                           input bit g, input bit perr, input bit serr,
                           input bit skip_idle, input bit b2b, input string tag);
    int      len;
    int      nc;
    int      b;
    int      t_start;
    status_t s;
    len          = (10 + int'(pe)) * p;
    cur_p        = p;
    cur_pe       = pe;
    prescale_drv = 6'(p);
    paren_drv    = pe;
    inj_g        = g;
    inj_p        = perr;
    inj_s        = serr;
    clear_obs();
    if (!g) begin
      s.dv = !((pe && perr) || serr);
      s.pe = pe && perr;
      s.se = serr;
      exp_q.push_back(s);
    end
    if (!skip_idle) begin
      rx_level = 1'b0;
      cycle();
    end
    t_start = cyc;
    nc      = g ? (p / 2 + 6) : (len + 1);
    for (int i = 1; i <= nc; i++) begin
      if (i == 1) begin
        prescale_drv = (p == 32) ? 6'd8 : 6'(2 * p);
        paren_drv    = !pe;
      end
      b = (i - 1) / p;
      if (g)              rx_level = (i == 1) ? 1'b0 : 1'b1;
      else if (i == nc)   rx_level = !b2b;
      else if (b == 0)    rx_level = 1'b0;
      else if (b <= 8)    rx_level = data[b-1];
      else if (pe && b == 9) rx_level = ^data;
      else                rx_level = 1'b1;
      cycle();
    end
    prescale_drv = 6'(p);
    paren_drv    = pe;
    inj_g = 1'b0; inj_p = 1'b0; inj_s = 1'b0;
    chk({tag, "_enable_cycles"}, n_en, g ? (p / 2 + 3) : len);
    chk({tag, "_deser_pulses"}, n_deser, g ? 0 : 8);
    chk({tag, "_strt_chk"}, n_strt, 1);
    chk({tag, "_par_chk"}, n_par, (pe && !g) ? 1 : 0);
    chk({tag, "_stp_chk"}, n_stp, g ? 0 : 1);
    chk({tag, "_strobe_placement"}, n_bad, 0);
    chk({tag, "_status_pulses"}, n_pulse, g ? 0 : 1);
    if (!g) chk({tag, "_status_cycle"}, pulse_cyc, t_start + len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET = 1'b0; RX_IN = 1'b0; PAR_EN = 1'b0; Prescale = 6'd8;
    bit_cnt = '0; edge_cnt = '0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;

    // Reset held with line low: outputs quiet
    rx_level = 1'b0;
    clear_obs();
    repeat (3) cycle();
    chk("reset_outputs", outs(), 9'd0);
    chk("reset_enable_cycles", n_en, 0);
    nRESET = 1'b1;

    // Line low at release: first edge enters START; 0xA5, Prescale 8
    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "p8_a5");
    idle_cycles(3);

    // Prescale 16 with parity, parity error injected
    run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "p16_parerr");
    idle_cycles(3);

    // Start glitch at edge 10: frame dropped
    run_frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "glitch");
    clear_obs();
    idle_cycles(4);
    chk("glitch_idle_after", n_en + n_pulse, 0);

    // Stop error, then a clean frame
    run_frame(8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "stperr");
    idle_cycles(2);
    run_frame(8, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_stperr");
    idle_cycles(2);

    // Back-to-back frames at Prescale 32: DONE goes straight to START
    run_frame(32, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_first");
    run_frame(32, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");
    idle_cycles(2);

    // Reset during data bit 4
    cur_p = 16; cur_pe = 1'b0; prescale_drv = 6'd16; paren_drv = 1'b0;
    rx_level = 1'b0;
    cycle();
    rx_level = 1'b1;
    repeat (4 * 16 + 3) cycle();
    chk("pre_reset_bit", m_bit, 4);
    chk("pre_reset_enable", enable, 1);
    #2;
    nRESET = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 9'd0);
    en_prev = enable;
    clear_obs();
    idle_cycles(2);
    chk("held_reset_outputs", outs(), 9'd0);
    nRESET = 1'b1;
    idle_cycles(3);
    chk("post_reset_idle", n_en + n_pulse, 0);
    run_frame(16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
    idle_cycles(2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have no parameters; widths are fixed as listed below.
REQ-002 CLK  in  1  receiver oversampling clock; reset nRESET, asynchronous, active-low; clock CLK.
REQ-003 nRESET  in  1  asynchronous active-low reset.
REQ-004 RX_IN  in  1  serial line, idle high.
REQ-005 PAR_EN  in  1  parity bit present in frame.
REQ-006 Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 bit_cnt  in  4  bit index from edge/bit counter: 0=start, 1..8=data, 9=parity or stop, 10=stop with parity.
REQ-008 edge_cnt  in  5  oversample index within current bit, 0..Prescale-1.
REQ-009 strt_glitch, par_err, stp_err  in  1 each  checker results, valid in cycle the matching check enable is high.
REQ-010 enable  out  1  run edge/bit counter.
REQ-011 dat_samp_en  out  1  enable 3-point majority sampler.
REQ-012 deser_en  out  1  one-cycle shift strobe per data bit.
REQ-013 strt_chk_en, par_chk_en, stp_chk_en  out  1 each  one-cycle check strobes.
REQ-014 data_valid  out  1  one-cycle pulse: error-free frame.
REQ-015 par_err_o, stp_err_o  out  1 each  one-cycle frame-status pulses, coincident with data_valid slot.

Function
REQ-016 SHALL be a Moore FSM with states IDLE, START, DATA, PARITY, STOP, DONE; all outputs registered or decoded from state plus counter inputs, no RX_IN-to-output combinational path.
REQ-017 CHK_EDGE SHALL equal Prescale/2+2 (6-bit); END_EDGE SHALL equal Prescale-1.
REQ-018 IDLE: RX_IN==0 -> START next cycle; otherwise stay.
REQ-019 enable SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE and DONE.
REQ-020 dat_samp_en SHALL be 1 in START, DATA, PARITY, STOP.
REQ-021 START: strt_chk_en=1 when edge_cnt==CHK_EDGE; strt_glitch=1 in that cycle -> IDLE next cycle (frame dropped, no strobes, no status pulse).
REQ-022 START: bit_cnt==0 and edge_cnt==END_EDGE -> DATA.
REQ-023 DATA: deser_en=1 when edge_cnt==CHK_EDGE, exactly 8 pulses per frame, LSB first.
REQ-024 DATA: bit_cnt==8 and edge_cnt==END_EDGE -> PARITY if PAR_EN else STOP.
REQ-025 PARITY: par_chk_en=1 at CHK_EDGE; par_err captured into sticky flag; edge_cnt==END_EDGE -> STOP.
REQ-026 STOP: stp_chk_en=1 at CHK_EDGE; stp_err captured into sticky flag; edge_cnt==END_EDGE -> DONE.
REQ-027 DONE (one cycle): data_valid=~(par flag | stp flag); par_err_o, stp_err_o = flags; flags cleared; RX_IN==0 -> START else IDLE.
REQ-028 PAR_EN and Prescale SHALL be sampled only in IDLE; mid-frame changes ignored until next frame.
REQ-029 Every strobe and pulse SHALL be exactly one CLK wide.

Reset
REQ-030 nRESET low SHALL force IDLE, clear sticky flags, drive every output 0, regardless of frame in progress.
REQ-031 After nRESET release with RX_IN low, SHALL enter START on first edge (treated as new frame; glitch check discards partial frames).

Structure
REQ-032 Shared package uart_rx_pkg SHALL hold state encoding and constants START_IDX=0, LAST_DATA_IDX=8, PAR_IDX=9, STOP_IDX_NOPAR=9, STOP_IDX_PAR=10.
REQ-033 No sub-module; edge_bit_counter, sampler, deserializer and checkers are siblings under the UART RX top.

Verification
REQ-034 Prescale=8, PAR_EN=0, byte 0xA5 -> 8 deser_en pulses, data_valid=1 one cycle after stop bit edge 7, errors 0.
REQ-035 Prescale=16, PAR_EN=1, par_err forced 1 at par_chk_en -> data_valid=0, par_err_o=1 single pulse.
REQ-036 RX_IN low 2 cycles, strt_glitch=1 at edge 10 (Prescale=16) -> IDLE, enable drops, no deser_en, no pulses.
REQ-037 stp_err=1 at stp_chk_en -> stp_err_o=1, data_valid=0; next frame clean -> data_valid=1.
REQ-038 Back-to-back frames, RX_IN low in DONE -> direct DONE->START, both frames data_valid=1.
REQ-039 nRESET asserted during DATA bit 4 -> all outputs 0 immediately, IDLE after release, next frame received correctly.
